// File: rtl/sipo_frame_if.sv
// sipo_frame_if: serial-line, SIPO and word-output bundle for sipo_frame_ctrl
interface sipo_frame_if #(parameter int WIDTH = 4);
  logic             din;
  logic             bit_vld;
  logic             sipo_load;
  logic [WIDTH-1:0] sipo_q;
  logic [WIDTH-1:0] word;
  logic             word_vld;
  logic             word_rdy;
  logic             busy;
  logic             frame_err;
  logic             overrun;
  modport master (
    output din, bit_vld, sipo_q, word_rdy,
    input  sipo_load, word, word_vld, busy, frame_err, overrun
  );
  modport slave (
    input  din, bit_vld, sipo_q, word_rdy,
    output sipo_load, word, word_vld, busy, frame_err, overrun
  );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: frames start/data/stop bits around an external SIPO and buffers decoded words
module sipo_frame_ctrl #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16
) (
  input logic        clk,
  input logic        rst,
  sipo_frame_if.slave bus
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int IW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
  state_t           state_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [IW-1:0]    idle_cnt_q;
  logic [WIDTH-1:0] word_q;
  logic             word_vld_q;
  logic             frame_err_q;
  logic             overrun_q;
  logic             tmo;
  // a strobe on the final idle cycle rescues the frame
  assign tmo = (TIMEOUT > 0) && (state_q != IDLE) && !bus.bit_vld && (idle_cnt_q == IW'(TIMEOUT - 1));
  assign bus.sipo_load = (state_q == DATA) && bus.bit_vld;
  assign bus.word      = word_q;
  assign bus.word_vld  = word_vld_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      word_q      <= '0;
      word_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (word_vld_q && bus.word_rdy) word_vld_q <= 1'b0;
      idle_cnt_q <= bus.bit_vld ? '0 : (idle_cnt_q == IW'(TIMEOUT) ? idle_cnt_q : idle_cnt_q + 1'b1);
      if (tmo) begin
        state_q     <= IDLE;
        frame_err_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: if (bus.bit_vld && !bus.din) begin
            state_q    <= DATA;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
          end
          DATA: if (bus.bit_vld) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == CW'(WIDTH - 1)) state_q <= STOP;
          end
          STOP: if (bus.bit_vld) begin
            state_q <= IDLE;
            if (!bus.din) frame_err_q <= 1'b1;
            else if (!word_vld_q || bus.word_rdy) begin
              word_q     <= bus.sipo_q;
              word_vld_q <= 1'b1;
            end else overrun_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb_sipo_frame_ctrl: directed frames into controller + SIPO, scoreboard monitor checks words and pulses
module tb_sipo_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sipo_frame_if #(.WIDTH(4)) bus ();
  sipo_frame_ctrl #(.WIDTH(4), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [3:0] sipo;
  always_ff @(posedge clk) begin
    if (rst) sipo <= '0;
    else if (bus.sipo_load) sipo <= {sipo[2:0], bus.din};
  end
  assign bus.sipo_q = sipo;
  int total = 0;
  int bad = 0;
  int loads = 0;
  logic [3:0] exp_w[$];
  int exp_err[$];
  int exp_ovr[$];
  always @(posedge clk) if (bus.sipo_load) loads++;
  task automatic chk(string n, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  // monitor: pops expectations whenever the DUT presents a word transfer or a pulse
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.word_vld && bus.word_rdy) begin
        chk("word_expected", int'(exp_w.size() > 0), 1);
        if (exp_w.size() > 0) chk("word", int'(bus.word), int'(exp_w.pop_front()));
      end
      if (bus.frame_err) begin
        chk("frame_err_expected", int'(exp_err.size() > 0), 1);
        if (exp_err.size() > 0) void'(exp_err.pop_front());
      end
      if (bus.overrun) begin
        chk("overrun_expected", int'(exp_ovr.size() > 0), 1);
        if (exp_ovr.size() > 0) void'(exp_ovr.pop_front());
      end
      if (bus.frame_err || bus.overrun) chk("err_ovr_exclusive", int'(bus.frame_err && bus.overrun), 0);
      if (bus.sipo_load) chk("load_only_busy", int'(bus.busy), 1);
    end
  end
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_bit(logic b);
    bus.din = b;
    bus.bit_vld = 1'b1;
    cyc(1);
    bus.bit_vld = 1'b0;
    bus.din = 1'b1;
  endtask
  task automatic frame(logic [3:0] d, logic stop, logic rdy_on_stop);
    logic r;
    send_bit(1'b0);
    cyc(1);
    for (int i = 3; i >= 0; i--) begin
      send_bit(d[i]);
      cyc(1);
    end
    r = bus.word_rdy;
    if (rdy_on_stop) bus.word_rdy = 1'b1;
    send_bit(stop);
    bus.word_rdy = r;
  endtask
  task automatic chk_all_zero(string n);
    chk({n, "_word"}, int'(bus.word), 0);
    chk({n, "_word_vld"}, int'(bus.word_vld), 0);
    chk({n, "_busy"}, int'(bus.busy), 0);
    chk({n, "_frame_err"}, int'(bus.frame_err), 0);
    chk({n, "_overrun"}, int'(bus.overrun), 0);
    chk({n, "_sipo_load"}, int'(bus.sipo_load), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int l0;
    bus.din = 1'b1;
    bus.bit_vld = 1'b0;
    bus.word_rdy = 1'b0;
    cyc(2);
    chk_all_zero("reset");
    rst = 1'b0;
    cyc(1);
    // 1: good frame 1011
    bus.word_rdy = 1'b1;
    l0 = loads;
    exp_w.push_back(4'b1011);
    frame(4'b1011, 1'b1, 1'b0);
    chk("t1_word_vld_rise", int'(bus.word_vld), 1);
    chk("t1_word", int'(bus.word), 4'b1011);
    chk("t1_loads", loads - l0, 4);
    cyc(1);
    chk("t1_word_vld_clear", int'(bus.word_vld), 0);
    chk("t1_busy", int'(bus.busy), 0);
    // 2: bad stop bit
    exp_err.push_back(2);
    frame(4'b1100, 1'b0, 1'b0);
    chk("t2_frame_err", int'(bus.frame_err), 1);
    chk("t2_busy", int'(bus.busy), 0);
    chk("t2_word_vld", int'(bus.word_vld), 0);
    cyc(1);
    chk("t2_frame_err_pulse", int'(bus.frame_err), 0);
    // 3: overrun
    bus.word_rdy = 1'b0;
    exp_w.push_back(4'b1011);
    frame(4'b1011, 1'b1, 1'b0);
    cyc(1);
    exp_ovr.push_back(3);
    frame(4'b0110, 1'b1, 1'b0);
    chk("t3_overrun", int'(bus.overrun), 1);
    chk("t3_word_kept", int'(bus.word), 4'b1011);
    chk("t3_word_vld", int'(bus.word_vld), 1);
    cyc(1);
    chk("t3_overrun_pulse", int'(bus.overrun), 0);
    bus.word_rdy = 1'b1;
    cyc(1);
    chk("t3_word_vld_clear", int'(bus.word_vld), 0);
    // 4: timeout after two data bits
    exp_err.push_back(4);
    send_bit(1'b0);
    cyc(1);
    send_bit(1'b1);
    cyc(1);
    send_bit(1'b0);
    cyc(15);
    chk("t4_busy_before", int'(bus.busy), 1);
    chk("t4_no_err_yet", int'(bus.frame_err), 0);
    cyc(1);
    chk("t4_frame_err", int'(bus.frame_err), 1);
    chk("t4_idle", int'(bus.busy), 0);
    exp_w.push_back(4'b0101);
    frame(4'b0101, 1'b1, 1'b0);
    chk("t4_word", int'(bus.word), 4'b0101);
    cyc(1);
    // 5: consume and capture on the same edge
    bus.word_rdy = 1'b0;
    exp_w.push_back(4'b1011);
    frame(4'b1011, 1'b1, 1'b0);
    cyc(1);
    exp_w.push_back(4'b0110);
    frame(4'b0110, 1'b1, 1'b1);
    chk("t5_word", int'(bus.word), 4'b0110);
    chk("t5_word_vld", int'(bus.word_vld), 1);
    chk("t5_no_overrun", int'(bus.overrun), 0);
    bus.word_rdy = 1'b1;
    cyc(1);
    chk("t5_word_vld_clear", int'(bus.word_vld), 0);
    // 6: reset mid-frame
    send_bit(1'b0);
    cyc(1);
    send_bit(1'b1);
    cyc(1);
    send_bit(1'b0);
    rst = 1'b1;
    bus.din = 1'b1;
    bus.bit_vld = 1'b1;
    cyc(1);
    chk_all_zero("t6_rst");
    cyc(1);
    rst = 1'b0;
    bus.bit_vld = 1'b0;
    cyc(1);
    exp_w.push_back(4'b1001);
    frame(4'b1001, 1'b1, 1'b0);
    chk("t6_word", int'(bus.word), 4'b1001);
    cyc(3);
    chk("words_left", exp_w.size(), 0);
    chk("errs_left", exp_err.size(), 0);
    chk("ovrs_left", exp_ovr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
